mult8x8_seq_ctrl: RTL



---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult8x8_seq_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built from one
// external 4x4 core.
package mult_pkg;

  localparam int NIB_W = 4;
  localparam int PP_W  = 8;
  localparam int ACC_W = 17;
  localparam int P_W   = 16;
  localparam logic [P_W-1:0] SAT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LL   = 3'd1,
    ST_LH   = 3'd2,
    ST_HL   = 3'd3,
    ST_HH   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // An approximate core can push the sum of four terms past 16 bits.
  function automatic logic [P_W-1:0] saturate(input logic [ACC_W-1:0] acc);
    return (acc > ACC_W'(SAT_MAX)) ? SAT_MAX : acc[P_W-1:0];
  endfunction

endpackage

// File: rtl/mult8x8_seq_ctrl.sv
// Sequencer that forms an 8x8 product from four nibble partial products,
// time-multiplexed through one external combinational 4x4 core.
module mult8x8_seq_ctrl
  import mult_pkg::*;
#(
  parameter bit SKIP_LL   = 1'b0,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  in_a,
  input  logic [PP_W-1:0]  in_b,
  output logic [NIB_W-1:0] mul_a,
  output logic [NIB_W-1:0] mul_b,
  input  logic [PP_W-1:0]  mul_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic             out_sat,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [PP_W-1:0]  a_q, a_d;
  logic [PP_W-1:0]  b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [P_W-1:0]   p_q, p_d;
  logic             sat_q, sat_d;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    p_d       = p_q;
    sat_d     = sat_q;
    mul_a     = '0;
    mul_b     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          acc_d = '0;
          if (ZERO_SKIP && (in_a == '0 || in_b == '0)) state_d = ST_DONE;
          else if (SKIP_LL)                            state_d = ST_LH;
          else                                         state_d = ST_LL;
        end
      end
      ST_LL: begin
        mul_a   = a_q[3:0];
        mul_b   = b_q[3:0];
        acc_d   = acc_q + ACC_W'(mul_r);
        state_d = ST_LH;
      end
      ST_LH: begin
        mul_a   = a_q[3:0];
        mul_b   = b_q[7:4];
        acc_d   = acc_q + (ACC_W'(mul_r) << 4);
        state_d = ST_HL;
      end
      ST_HL: begin
        mul_a   = a_q[7:4];
        mul_b   = b_q[3:0];
        acc_d   = acc_q + (ACC_W'(mul_r) << 4);
        state_d = ST_HH;
      end
      ST_HH: begin
        mul_a   = a_q[7:4];
        mul_b   = b_q[7:4];
        acc_d   = acc_q + (ACC_W'(mul_r) << 8);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Result is frozen on entry to DONE and held until the next DONE.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      p_d   = saturate(acc_d);
      sat_d = (acc_d > ACC_W'(SAT_MAX));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      sat_q   <= sat_d;
    end
  end

  assign out_p   = p_q;
  assign out_sat = sat_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
